// File: rtl/mdu_pkg.sv
// Shared definitions for the mul/div unit: op and FSM encodings, default XLEN.
package mdu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // funct3[1:0] of the RV32M divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_radix2_seq_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_radix2_seq_if
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            i_start;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_dividend;
  logic [XLEN-1:0] i_divisor;
  logic            i_flush;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_op, i_dividend, i_divisor, i_flush,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_op, i_dividend, i_divisor, i_flush,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/div_radix2_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs_abs,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem_in < dvs_abs always holds, so the shifted value fits in XLEN+1 bits
  // and bit XLEN of the trial difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, dvs_abs};
    q_bit   = !trial[XLEN];
    rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/div_radix2_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional result cache enabled by defining MDU_DIV_CACHE_EN.
module div_radix2_seq
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  div_radix2_seq_if.slave  bus
);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state, nxt;
  op_e             op_in, op_q;
  logic            sgn_in, div_zero, ovf, special, accept, hit;
  logic [XLEN-1:0] dvd_abs, dvs_abs_in, hit_res;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic [XLEN-1:0] rem_nxt, q_fix, r_fix;
  logic            q_bit, neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  assign op_in      = op_e'(bus.i_op);
  assign sgn_in     = op_is_signed(op_in);
  assign div_zero   = (bus.i_divisor == '0);
  assign ovf        = sgn_in && (bus.i_dividend == MIN_INT) && (bus.i_divisor == '1);
  assign special    = div_zero || ovf;
  assign accept     = (state == ST_IDLE) && bus.i_start && !bus.i_flush;
  assign dvd_abs    = (sgn_in && bus.i_dividend[XLEN-1]) ? -bus.i_dividend : bus.i_dividend;
  assign dvs_abs_in = (sgn_in && bus.i_divisor[XLEN-1])  ? -bus.i_divisor  : bus.i_divisor;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[XLEN-1]),
    .dvs_abs (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Sign correction of the final magnitudes
  always_comb begin
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r ? -rem_q : rem_q;
  end

`ifdef MDU_DIV_CACHE_EN
  logic            c_vld, c_sgn;
  logic [XLEN-1:0] c_dvd, c_dvs, c_quo, c_rem, dvd_raw_q, dvs_raw_q;
  logic            sgn_q;

  assign hit     = c_vld && (bus.i_dividend == c_dvd) && (bus.i_divisor == c_dvs) && (sgn_in == c_sgn);
  assign hit_res = op_is_rem(op_in) ? c_rem : c_quo;

  // Remember the last completed normal op; any flush or special case drops it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_vld <= 1'b0; c_sgn <= 1'b0; sgn_q <= 1'b0;
      c_dvd <= '0; c_dvs <= '0; c_quo <= '0; c_rem <= '0;
      dvd_raw_q <= '0; dvs_raw_q <= '0;
    end else if (bus.i_flush) begin
      c_vld <= 1'b0;
    end else if (accept) begin
      dvd_raw_q <= bus.i_dividend;
      dvs_raw_q <= bus.i_divisor;
      sgn_q     <= sgn_in;
      if (special) c_vld <= 1'b0;
    end else if (state == ST_FIX) begin
      c_vld <= 1'b1;
      c_sgn <= sgn_q;
      c_dvd <= dvd_raw_q;
      c_dvs <= dvs_raw_q;
      c_quo <= q_fix;
      c_rem <= r_fix;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (accept) nxt = (special || hit) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0) nxt = ST_FIX;
      ST_FIX:  nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    if (bus.i_flush) nxt = ST_IDLE;
  end

  // Datapath: operand latch, iteration, result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q  <= OP_DIV;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          op_q  <= op_in;
          neg_q <= sgn_in && (bus.i_dividend[XLEN-1] ^ bus.i_divisor[XLEN-1]);
          neg_r <= sgn_in && bus.i_dividend[XLEN-1];
          cnt   <= CNT_W'(XLEN - 1);
          rem_q <= '0;
          quo_q <= dvd_abs;
          dvs_q <= dvs_abs_in;
          if (div_zero)  res_q <= op_is_rem(op_in) ? bus.i_dividend : '1;
          else if (ovf)  res_q <= op_is_rem(op_in) ? '0 : MIN_INT;
          else if (hit)  res_q <= hit_res;
        end
        ST_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[XLEN-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        ST_FIX: if (!bus.i_flush) res_q <= op_is_rem(op_q) ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

  assign bus.o_busy   = (state != ST_IDLE);
  assign bus.o_valid  = (state == ST_DONE);
  assign bus.o_result = res_q;

endmodule
